// File: rtl/contador_step_pkg.sv
// Shared constants for the control-unit step counter and its consumers
// (control FSM, instruction decoder).
package contador_step_pkg;

   localparam int unsigned MODE_WRAP = 0;
   localparam int unsigned MODE_SAT  = 1;

   localparam int unsigned STEP_N      = 3;
   localparam int unsigned STEP_MODULO = 8;

   typedef enum logic [2:0] {
      ActHold,
      ActClear,
      ActLoad,
      ActInc,
      ActDec
   } step_act_e;

endpackage

// File: rtl/contador_step_dec_onehot.sv
// Enable-gated N-to-M one-hot decoder; bit i is set iff en is high and sel == i.
module dec_onehot #(
   parameter int unsigned N = 3,
   parameter int unsigned M = 8
) (
   input  logic         en,
   input  logic [N-1:0] sel,
   output logic [M-1:0] y
);

   always_comb begin
      y = '0;
      for (int i = 0; i < M; i++) begin
         if (en && (sel == N'(i))) begin
            y[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/contador_step.sv
// Parametrised up/down step counter with load clamp, wrap/saturate mode,
// registered boundary flag and gated one-hot time-step decode.
module contador_step
   import contador_step_pkg::*;
#(
   parameter int unsigned N        = STEP_N,
   parameter int unsigned MODULO   = STEP_MODULO,
   parameter int unsigned SATURATE = MODE_WRAP
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Clear,
   input  logic              En,
   input  logic              Load,
   input  logic              Up,
   input  logic [N-1:0]      D,
   input  logic              DecEn,
   output logic [N-1:0]      Q,
   output logic              Wrap,
   output logic [MODULO-1:0] Y
);

   if ((MODULO < 2) || (MODULO > (1 << N))) begin : gen_bad_modulo
      $error("contador_step: MODULO must lie in 2..2**N");
   end

   localparam logic [N-1:0] MAX_Q = N'(MODULO - 1);
   localparam logic [N-1:0] ONE   = N'(1);
   localparam bit           SAT   = (SATURATE == MODE_SAT);

   logic [N-1:0] q_q, q_d;
   logic         wrap_q, wrap_d;
   logic [N-1:0] load_val;
   logic         at_top, at_bot;
   step_act_e    act;

   always_comb begin
      act = ActHold;
      if (Clear) begin
         act = ActClear;
      end else if (Load) begin
         act = ActLoad;
      end else if (En) begin
         act = Up ? ActInc : ActDec;
      end
   end

   // Out-of-range loads clamp to the top of the range so Q never leaves 0..MODULO-1.
   assign load_val = (D > MAX_Q) ? MAX_Q : D;
   assign at_top   = (q_q == MAX_Q);
   assign at_bot   = (q_q == '0);

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      unique case (act)
         ActHold:  q_d = q_q;
         ActClear: q_d = '0;
         ActLoad:  q_d = load_val;
         ActInc: begin
            if (at_top) begin
               wrap_d = 1'b1;
               q_d    = SAT ? q_q : '0;
            end else begin
               q_d = q_q + ONE;
            end
         end
         ActDec: begin
            if (at_bot) begin
               wrap_d = 1'b1;
               q_d    = SAT ? q_q : MAX_Q;
            end else begin
               q_d = q_q - ONE;
            end
         end
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign Q    = q_q;
   assign Wrap = wrap_q;

   dec_onehot #(
      .N (N),
      .M (MODULO)
   ) u_dec (
      .en  (DecEn),
      .sel (q_q),
      .y   (Y)
   );

endmodule

// File: tb/tb_contador_step.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are checked against an arithmetic reference model.
module tb_contador_step;

   logic       Clock = 1'b0;
   logic       Resetn, Clear, En, Load, Up, DecEn;
   logic [2:0] D;

   logic [2:0] q_def, q_m5, q_sat;
   logic       w_def, w_m5, w_sat;
   logic [7:0] y_def, y_sat;
   logic [4:0] y_m5;

   always #5 Clock = ~Clock;

   contador_step #(.N(3), .MODULO(8), .SATURATE(0)) u_def (
      .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .En(En), .Load(Load), .Up(Up),
      .D(D), .DecEn(DecEn), .Q(q_def), .Wrap(w_def), .Y(y_def));
   contador_step #(.N(3), .MODULO(5), .SATURATE(0)) u_m5 (
      .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .En(En), .Load(Load), .Up(Up),
      .D(D), .DecEn(DecEn), .Q(q_m5), .Wrap(w_m5), .Y(y_m5));
   contador_step #(.N(3), .MODULO(8), .SATURATE(1)) u_sat (
      .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .En(En), .Load(Load), .Up(Up),
      .D(D), .DecEn(DecEn), .Q(q_sat), .Wrap(w_sat), .Y(y_sat));

   typedef struct packed {
      logic [2:0][7:0] y;
      logic [2:0]      w;
      logic [2:0][2:0] q;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   failed   = 0;

   int mq[3];
   bit mw[3];
   int modv[3];
   bit satv[3];

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mq[k] = 0;
         mw[k] = 1'b0;
      end
   endtask

   // Behaviour expressed as modular arithmetic on integers.
   task automatic model_step();
      bit bnd;
      if (!Resetn) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 3; k++) begin
         if (Clear) begin
            mq[k] = 0;
            mw[k] = 1'b0;
         end else if (Load) begin
            mq[k] = (int'(D) < modv[k]) ? int'(D) : modv[k] - 1;
            mw[k] = 1'b0;
         end else if (En) begin
            bnd   = Up ? (mq[k] == modv[k] - 1) : (mq[k] == 0);
            mw[k] = bnd;
            if (!(bnd && satv[k])) mq[k] = (mq[k] + (Up ? 1 : modv[k] - 1)) % modv[k];
         end else begin
            mw[k] = 1'b0;
         end
      end
   endtask

   task automatic push_exp();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         e.q[k] = 3'(mq[k]);
         e.w[k] = mw[k];
         e.y[k] = DecEn ? 8'(1 << mq[k]) : 8'h00;
      end
      sb.push_back(e);
   endtask

   // One clock edge; optionally drop Resetn between edges after it.
   task automatic tick(input bit async_rst);
      @(posedge Clock);
      model_step();
      #1;
      if (async_rst) begin
         Resetn = 1'b0;
         model_reset();
      end
      push_exp();
      @(negedge Clock);
      #1;
   endtask

   task automatic cmp(input string nm, input int act, input int expv);
      compared++;
      if (act != expv) begin
         failed++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
      end
   endtask

   always @(negedge Clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp("q_def", int'(q_def), int'(e.q[0]));
         cmp("wrap_def", int'(w_def), int'(e.w[0]));
         cmp("y_def", int'(y_def), int'(e.y[0]));
         cmp("q_m5", int'(q_m5), int'(e.q[1]));
         cmp("wrap_m5", int'(w_m5), int'(e.w[1]));
         cmp("y_m5", int'({3'b000, y_m5}), int'(e.y[1]));
         cmp("q_sat", int'(q_sat), int'(e.q[2]));
         cmp("wrap_sat", int'(w_sat), int'(e.w[2]));
         cmp("y_sat", int'(y_sat), int'(e.y[2]));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic set_in(input bit c, input bit l, input bit e, input bit u,
                         input int d, input bit de);
      Clear = c;
      Load  = l;
      En    = e;
      Up    = u;
      D     = 3'(d);
      DecEn = de;
   endtask

   initial begin
      modv = '{8, 5, 8};
      satv = '{1'b0, 1'b0, 1'b1};
      model_reset();
      Resetn = 1'b0;
      set_in(0, 0, 0, 1, 0, 1);
      tick(0);
      tick(0);
      Resetn = 1'b1;

      // Count up through the wrap point.
      set_in(0, 0, 1, 1, 0, 1);
      repeat (9) tick(0);

      // Reset asserted between edges with Q = 5.
      set_in(1, 0, 0, 1, 0, 1);
      tick(0);
      set_in(0, 0, 1, 1, 0, 1);
      repeat (5) tick(0);
      set_in(0, 0, 0, 1, 0, 1);
      tick(1);
      tick(0);
      Resetn = 1'b1;

      // Count down from 0, wrapping to MODULO-1.
      set_in(0, 0, 1, 0, 0, 1);
      repeat (6) tick(0);

      // Up to the top, hold at boundary, then step down once.
      set_in(1, 0, 0, 1, 0, 1);
      tick(0);
      set_in(0, 0, 1, 1, 0, 1);
      repeat (10) tick(0);
      set_in(0, 0, 1, 0, 0, 1);
      tick(0);

      // Priority Clear > Load > En, then clamped load.
      set_in(1, 1, 1, 1, 5, 1);
      tick(0);
      set_in(0, 1, 1, 1, 6, 1);
      tick(0);

      // Decode gating at Q = 3.
      set_in(0, 1, 0, 1, 3, 1);
      tick(0);
      set_in(0, 0, 0, 1, 0, 1);
      tick(0);
      set_in(0, 0, 0, 1, 0, 0);
      tick(0);
      set_in(0, 0, 0, 1, 0, 1);
      tick(0);

      for (int i = 0; i < 400; i++) begin
         Resetn = 1'b1;
         set_in($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0);
         tick($urandom_range(0, 49) == 0);
      end
      Resetn = 1'b1;

      compared++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
